sdram_chip_model: RTL and testbench

Parametrised cycle-level behavioural model of a single-rank SDR SDRAM device for the SoC simulation environment; it sits on the SDRAM controller's pin-level bus in place of the fixed 16-bit device model. It generalises data width, row/column/bank geometry and CAS latency, and tracks per-bank open rows with precharge. It also supports wrapped sequential bursts, burst interruption, DQM-masked writes, refresh counting and a sticky protocol-error flag for the verification environment.

---
 rtl/sdram_model_pkg.sv | 55 +++++
 rtl/sdram_chip_model_if.sv | 17 +
 rtl/sdram_read_pipe.sv | 46 ++++
 rtl/sdram_chip_model.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_chip_model.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_model_pkg.sv
// rtl/sdram_model_pkg.sv - shared command, mode-register and state definitions for the SDRAM model
package sdram_model_pkg;

  // {cs, ras, cas, we} command encodings; cs=1 is decoded as NOP before the cast
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_BST       = 4'b0110,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    BURST_IDLE,
    BURST_READ,
    BURST_WRITE
  } burst_state_e;

  // Mode register field positions on the address bus
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_W   = 3;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_W   = 3;

  // Legal CAS latencies form the contiguous set {CL_MIN..CL_MAX}
  localparam int CL_MIN     = 2;
  localparam int CL_MAX     = 3;
  localparam int BL_MAX     = 8;
  localparam int BL_LOG_MAX = 3;

  function automatic logic cl_legal(input logic [MODE_CL_W-1:0] cl);
    return (cl >= MODE_CL_W'(CL_MIN)) && (cl <= MODE_CL_W'(CL_MAX));
  endfunction

  // Low-bit mask of the BL-aligned wrap block, i.e. BL-1
  function automatic logic [2:0] bl_mask(input logic [1:0] bl_log);
    logic [2:0] m;
    case (bl_log)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      default: m = 3'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sdram_chip_model_if.sv
// rtl/sdram_chip_model_if.sv - SDRAM command/address/mask pins between controller and device model
interface sdram_chip_model_if #(
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
);
  logic              cke;
  logic              cs;
  logic              ras;
  logic              cas;
  logic              we;
  logic [12:0]       a;
  logic [BANK_W-1:0] ba;
  logic [DATA_W/8-1:0] dqm;

  modport master (output cke, cs, ras, cas, we, a, ba, dqm);
  modport slave  (input  cke, cs, ras, cas, we, a, ba, dqm);
endinterface

// File: rtl/sdram_read_pipe.sv
// rtl/sdram_read_pipe.sv - CAS-latency delay line feeding the dq read driver
module sdram_read_pipe
  import sdram_model_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        cl,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              oe,
  output logic [DATA_W-1:0] data
);

  logic [CL_MAX-1:0] vld;
  logic [DATA_W-1:0] dat [CL_MAX];
  logic [1:0]        wr_idx;

  // A beat entered at slot CL-1 reaches slot 0 (the driven slot) CL-1 edges later
  assign wr_idx = 2'(cl - 3'd1);

  // Valid bits shift toward the output; async reset empties the line and frees dq at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      for (int i = 0; i < CL_MAX - 1; i++) vld[i] <= vld[i+1];
      vld[CL_MAX-1] <= 1'b0;
      if (push) vld[wr_idx] <= 1'b1;
    end
  end

  // Data payload follows the valid bits; its contents are meaningless while invalid
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < CL_MAX - 1; i++) dat[i] <= dat[i+1];
      if (push) dat[wr_idx] <= push_data;
    end
  end

  assign oe   = vld[0];
  assign data = dat[0];

endmodule

// File: rtl/sdram_chip_model.sv
// rtl/sdram_chip_model.sv - cycle-level SDR SDRAM device model; SDRAM_MODEL_AUTOPRECHARGE_EN enables a[10] auto-precharge
module sdram_chip_model
  import sdram_model_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  sdram_chip_model_if.slave bus,
  inout  wire [DATA_W-1:0]  dq,
  output logic              err,
  output logic [15:0]       refresh_cnt
);

`ifdef SDRAM_MODEL_AUTOPRECHARGE_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  localparam int NBANK  = 1 << BANK_W;
  localparam int NBYTE  = DATA_W / 8;
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int KW     = $clog2(BL_MAX);

  // Storage is never cleared; rst only affects control state
  logic [DATA_W-1:0] mem [DEPTH];

  bank_state_e       bank_state [NBANK];
  logic [ROW_W-1:0]  open_row   [NBANK];
  logic [1:0]        bl_log;
  logic [2:0]        cl;

  burst_state_e      burst_state, burst_state_n;
  logic [BANK_W-1:0] burst_bank,  burst_bank_n;
  logic [COL_W-1:0]  burst_col,   burst_col_n;
  logic [KW-1:0]     burst_k,     burst_k_n;
  logic              burst_ap,    burst_ap_n;

  cmd_e              cmd;
  logic              any_active;
  logic              new_burst;
  logic              trunc_old;
  logic              stop_cmd;
  logic              beat_go;
  logic              beat_wr;
  logic              beat_ap;
  logic              beat_last;
  logic [BANK_W-1:0] beat_bank;
  logic [COL_W-1:0]  beat_col0;
  logic [KW-1:0]     beat_k;
  logic [COL_W-1:0]  col_mask;
  logic [COL_W-1:0]  beat_col;
  logic [ADDR_W-1:0] beat_addr;
  logic              close_old;
  logic              close_new;
  logic              mem_we;
  logic [2:0]        bl_fld;
  logic [2:0]        cl_fld;
  logic              rd_oe;
  logic [DATA_W-1:0] rd_data;

  // Command decode; a deselected chip or a frozen clock is a NOP
  always_comb begin
    cmd = CMD_NOP;
    if (bus.cke && !bus.cs) cmd = cmd_e'({bus.cs, bus.ras, bus.cas, bus.we});
  end

  // Any open bank blocks LOAD MODE and makes AUTO REFRESH illegal
  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      if (bank_state[i] == BANK_ACTIVE) any_active = 1'b1;
    end
  end

  assign bl_fld = bus.a[MODE_BL_LSB +: MODE_BL_W];
  assign cl_fld = bus.a[MODE_CL_LSB +: MODE_CL_W];

  // Burst sequencer: picks this edge's beat (new command or continuation) and the next burst state
  always_comb begin
    burst_state_n = burst_state;
    burst_bank_n  = burst_bank;
    burst_col_n   = burst_col;
    burst_k_n     = burst_k;
    burst_ap_n    = burst_ap;
    beat_go       = 1'b0;
    beat_wr       = 1'b0;
    beat_bank     = burst_bank;
    beat_col0     = burst_col;
    beat_k        = burst_k;
    beat_ap       = burst_ap;
    trunc_old     = 1'b0;
    new_burst     = ((cmd == CMD_READ) || (cmd == CMD_WRITE)) &&
                    (bank_state[bus.ba] == BANK_ACTIVE);
    if (new_burst) begin
      trunc_old = (burst_state != BURST_IDLE);
      beat_go   = 1'b1;
      beat_wr   = (cmd == CMD_WRITE);
      beat_bank = bus.ba;
      beat_col0 = bus.a[COL_W-1:0];
      beat_k    = '0;
      beat_ap   = AP_EN && bus.a[10];
    end else if (burst_state != BURST_IDLE) begin
      beat_go = 1'b1;
      beat_wr = (burst_state == BURST_WRITE);
    end
    // BST and a PRECHARGE of the burst bank let the current beat through, then end the burst
    stop_cmd  = !new_burst && ((cmd == CMD_BST) ||
                ((cmd == CMD_PRECHARGE) && (bus.a[10] || (bus.ba == burst_bank))));
    beat_last = (beat_k == bl_mask(bl_log));
    if (beat_go) begin
      if (beat_last || stop_cmd) begin
        burst_state_n = BURST_IDLE;
      end else begin
        burst_state_n = beat_wr ? BURST_WRITE : BURST_READ;
        burst_bank_n  = beat_bank;
        burst_col_n   = beat_col0;
        burst_k_n     = beat_k + KW'(1);
        burst_ap_n    = beat_ap;
      end
    end
    close_old = AP_EN && trunc_old && burst_ap;
    close_new = AP_EN && beat_go && beat_ap && (beat_last || stop_cmd);
  end

  // Sequential wrap inside the BL-aligned column block
  assign col_mask  = COL_W'(bl_mask(bl_log));
  assign beat_col  = (beat_col0 & ~col_mask) | ((beat_col0 + COL_W'(beat_k)) & col_mask);
  assign beat_addr = {open_row[beat_bank], beat_bank, beat_col};
  assign mem_we    = bus.cke && !rst && beat_go && beat_wr;

  // Burst state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_state <= BURST_IDLE;
      burst_bank  <= '0;
      burst_col   <= '0;
      burst_k     <= '0;
      burst_ap    <= 1'b0;
    end else if (bus.cke) begin
      burst_state <= burst_state_n;
      burst_bank  <= burst_bank_n;
      burst_col   <= burst_col_n;
      burst_k     <= burst_k_n;
      burst_ap    <= burst_ap_n;
    end
  end

  // Bank, mode register, refresh counter and sticky error updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++) begin
        bank_state[i] <= BANK_IDLE;
        open_row[i]   <= '0;
      end
      bl_log      <= 2'd0;
      cl          <= 3'(CL_MIN);
      err         <= 1'b0;
      refresh_cnt <= '0;
    end else if (bus.cke) begin
      if (close_old) bank_state[burst_bank] <= BANK_IDLE;
      if (close_new) bank_state[beat_bank]  <= BANK_IDLE;
      case (cmd)
        CMD_ACTIVE: begin
          if (bank_state[bus.ba] == BANK_ACTIVE) begin
            err <= 1'b1;
          end else begin
            bank_state[bus.ba] <= BANK_ACTIVE;
            open_row[bus.ba]   <= bus.a[ROW_W-1:0];
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (bank_state[bus.ba] == BANK_IDLE) err <= 1'b1;
        end
        CMD_PRECHARGE: begin
          if (bus.a[10]) begin
            for (int i = 0; i < NBANK; i++) bank_state[i] <= BANK_IDLE;
          end else begin
            bank_state[bus.ba] <= BANK_IDLE;
          end
        end
        CMD_REFRESH: begin
          refresh_cnt <= refresh_cnt + 16'd1;
          if (any_active) err <= 1'b1;
        end
        CMD_LOAD_MODE: begin
          if (any_active) begin
            err <= 1'b1;
          end else begin
            if (bl_fld > 3'(BL_LOG_MAX)) err <= 1'b1;
            else                         bl_log <= bl_fld[1:0];
            if (!cl_legal(cl_fld))       err <= 1'b1;
            else                         cl <= cl_fld;
          end
        end
        default: ;
      endcase
    end
  end

  // Masked write of the current write beat straight from the dq pins
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (!bus.dqm[i]) mem[beat_addr][i*8 +: 8] <= dq[i*8 +: 8];
      end
    end
  end

  sdram_read_pipe #(.DATA_W(DATA_W)) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.cke),
    .cl        (cl),
    .push      (beat_go && !beat_wr),
    .push_data (mem[beat_addr]),
    .oe        (rd_oe),
    .data      (rd_data)
  );

  assign dq = rd_oe ? rd_data : 'z;

endmodule

// File: tb/tb_sdram_chip_model.sv
// tb/tb_sdram_chip_model.sv - directed self-checking bench for sdram_chip_model
module tb_sdram_chip_model;
  import sdram_model_pkg::*;

  logic        clk;
  logic        rst;
  wire  [15:0] dq;
  logic        tb_oe;
  logic [15:0] tb_dq;
  logic        err;
  logic [15:0] refresh_cnt;
  int          n_tests;
  int          n_fail;

  sdram_chip_model_if #(.BANK_W(2), .DATA_W(16)) bus_if ();

  sdram_chip_model #(
    .DATA_W (16),
    .ROW_W  (8),
    .COL_W  (6),
    .BANK_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .dq          (dq),
    .err         (err),
    .refresh_cnt (refresh_cnt)
  );

  assign dq = tb_oe ? tb_dq : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // A released bus has no bit pulled to 1, whether it reads back as z or 0
  task automatic check_rel(input string tag);
    check_eq(tag, $countones(dq), 0);
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic oe, input logic [1:0] m);
    {bus_if.cs, bus_if.ras, bus_if.cas, bus_if.we} = c;
    bus_if.ba  = b;
    bus_if.a   = addr;
    bus_if.dqm = m;
    tb_dq      = d;
    tb_oe      = oe;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr);
    issue(c, b, addr, 16'h0000, 1'b0, 2'b00);
  endtask

  task automatic nop();
    do_cmd(CMD_NOP, 2'd0, 13'h000);
  endtask

  task automatic reset_pulse();
    {bus_if.cs, bus_if.ras, bus_if.cas, bus_if.we} = 4'b1111;
    tb_oe = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  // Called right after a READ with CL=2: beat k is seen at the negedge after T+1+k
  task automatic read_check(input string tag, input logic [15:0] exp_q[$]);
    foreach (exp_q[i]) begin
      nop();
      check_eq($sformatf("%s[%0d]", tag, i), dq, exp_q[i]);
    end
    nop();
    check_rel({tag, "_end"});
  endtask

  initial begin
    logic [15:0] exp_q[$];
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    tb_oe      = 1'b0;
    tb_dq      = '0;
    bus_if.cke = 1'b1;
    bus_if.cs  = 1'b1;
    bus_if.ras = 1'b1;
    bus_if.cas = 1'b1;
    bus_if.we  = 1'b1;
    bus_if.a   = '0;
    bus_if.ba  = '0;
    bus_if.dqm = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_err", err, 0);
    check_eq("rst_refcnt", refresh_cnt, 0);
    check_rel("rst_dq");
    rst = 1'b0;

    // Reset mode is BL=1, CL=2
    do_cmd(CMD_ACTIVE, 2'd0, 13'h001);
    issue(CMD_WRITE, 2'd0, 13'h004, 16'h5555, 1'b1, 2'b00);
    issue(CMD_WRITE, 2'd0, 13'h003, 16'h1234, 1'b1, 2'b00);
    issue(CMD_NOP,   2'd0, 13'h000, 16'h9999, 1'b1, 2'b00);
    do_cmd(CMD_READ, 2'd0, 13'h004);
    check_rel("cl2_gap");
    exp_q = '{16'h5555};
    read_check("bl1_c4", exp_q);
    do_cmd(CMD_READ, 2'd0, 13'h003);
    exp_q = '{16'h1234};
    read_check("bl1_c3", exp_q);
    issue(CMD_WRITE, 2'd0, 13'h003, 16'hABCD, 1'b1, 2'b10);
    do_cmd(CMD_READ, 2'd0, 13'h003);
    exp_q = '{16'h12CD};
    read_check("dqm", exp_q);

    // BL=8, CL=2 wrapped bursts on bank 1 row 0x55
    do_cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h023);
    do_cmd(CMD_ACTIVE, 2'd1, 13'h055);
    issue(CMD_WRITE, 2'd1, 13'h004, 16'h1000, 1'b1, 2'b00);
    for (int k = 1; k < 8; k++) issue(CMD_NOP, 2'd0, 13'h000, 16'h1000 + 16'(k), 1'b1, 2'b00);
    issue(CMD_WRITE, 2'd1, 13'h010, 16'h2000, 1'b1, 2'b00);
    for (int k = 1; k < 8; k++) issue(CMD_NOP, 2'd0, 13'h000, 16'h2000 + 16'(k), 1'b1, 2'b00);

    do_cmd(CMD_READ, 2'd1, 13'h004);
    exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007};
    for (int k = 0; k < 8; k++) begin
      nop();
      check_eq($sformatf("bl8_c4[%0d]", k), dq, exp_q[k]);
      if (k == 2) begin
        bus_if.cke = 1'b0;
        nop();
        check_eq("cke_hold0", dq, 16'h1002);
        nop();
        check_eq("cke_hold1", dq, 16'h1002);
        bus_if.cke = 1'b1;
      end
    end
    nop();
    check_rel("bl8_c4_end");

    do_cmd(CMD_READ, 2'd1, 13'h000);
    exp_q = '{16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001, 16'h1002, 16'h1003};
    read_check("bl8_wrap", exp_q);
    check_eq("err_clean", err, 0);

    // CL=3, BL=4 with BURST TERMINATE one edge after the READ
    do_cmd(CMD_PRECHARGE, 2'd1, 13'h000);
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h032);
    do_cmd(CMD_ACTIVE, 2'd1, 13'h055);
    do_cmd(CMD_READ, 2'd1, 13'h010);
    check_rel("cl3_t0");
    do_cmd(CMD_BST, 2'd0, 13'h000);
    check_rel("cl3_t1");
    nop();
    check_eq("bst_b0", dq, 16'h2000);
    nop();
    check_eq("bst_b1", dq, 16'h2001);
    nop();
    check_rel("bst_end0");
    nop();
    check_rel("bst_end1");

    do_cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    do_cmd(CMD_REFRESH, 2'd0, 13'h000);
    do_cmd(CMD_REFRESH, 2'd0, 13'h000);
    check_eq("refcnt2", refresh_cnt, 2);
    check_eq("ref_idle_err", err, 0);

    // BL=2 write with a[10]=1, then READ of the same bank
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h021);
    do_cmd(CMD_ACTIVE, 2'd2, 13'h003);
    issue(CMD_WRITE, 2'd2, 13'h408, 16'h3000, 1'b1, 2'b00);
    issue(CMD_NOP,   2'd0, 13'h000, 16'h3001, 1'b1, 2'b00);
    do_cmd(CMD_READ, 2'd2, 13'h008);
`ifdef SDRAM_MODEL_AUTOPRECHARGE_EN
    check_eq("ap_err", err, 1);
`else
    check_eq("noap_err", err, 0);
    exp_q = '{16'h3000, 16'h3001};
    read_check("noap_rd", exp_q);
`endif

    // Protocol errors and reset recovery
    reset_pulse();
    check_eq("rst2_err", err, 0);
    check_eq("rst2_refcnt", refresh_cnt, 0);
    do_cmd(CMD_READ, 2'd0, 13'h000);
    check_eq("rd_idle_err", err, 1);
    nop();
    nop();
    check_eq("err_sticky", err, 1);

    reset_pulse();
    do_cmd(CMD_ACTIVE, 2'd0, 13'h001);
    check_eq("act_ok_err", err, 0);
    do_cmd(CMD_ACTIVE, 2'd0, 13'h002);
    check_eq("act_act_err", err, 1);

    reset_pulse();
    do_cmd(CMD_ACTIVE, 2'd3, 13'h001);
    do_cmd(CMD_REFRESH, 2'd0, 13'h000);
    check_eq("ref_act_cnt", refresh_cnt, 1);
    check_eq("ref_act_err", err, 1);

    reset_pulse();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h050);
    check_eq("bad_cl_err", err, 1);

    reset_pulse();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h024);
    check_eq("bad_bl_err", err, 1);

    // Asynchronous reset in the middle of a read burst
    reset_pulse();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h023);
    do_cmd(CMD_ACTIVE, 2'd1, 13'h055);
    do_cmd(CMD_READ, 2'd1, 13'h004);
    nop();
    check_eq("pre_arst_b0", dq, 16'h1000);
    nop();
    check_eq("pre_arst_b1", dq, 16'h1001);
    rst = 1'b1;
    #1;
    check_rel("arst_dq");
    check_eq("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
